md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, SHALL set the busy duration in cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10, SHALL set the busy duration in cycles for div/divu.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 A  input  32  SHALL be operand 1: multiplicand, dividend, or mthi/mtlo data.
REQ-006 B  input  32  SHALL be operand 2: multiplier or divisor.
REQ-007 Op  input  3  SHALL encode the operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op).
REQ-008 Start  input  1  SHALL qualify Op and operands for one cycle.
REQ-009 Busy  output  1  SHALL be registered and high while a mult/div is in flight.
REQ-010 HI  output  32  SHALL be the architectural HI register.
REQ-011 LO  output  32  SHALL be the architectural LO register.

Function
REQ-012 Acceptance SHALL occur on a rising edge where Start=1, Busy=0 and Op is in 1..6.
REQ-013 Start while Busy=1 SHALL be ignored: no state change, and the in-flight operation is unaffected.
REQ-014 mult/multu acceptance SHALL latch the 64-bit product (signed/unsigned) into pending registers, load the counter with MULT_CYCLES, and set Busy=1 on that edge.
REQ-015 div/divu acceptance SHALL latch quotient (to pending LO) and remainder (to pending HI), load the counter with DIV_CYCLES, and set Busy=1.
REQ-016 State machine SHALL have two states, IDLE and RUN.
REQ-017 IDLE SHALL go to RUN on accepted mult/div.
REQ-018 In RUN, the counter SHALL decrement each edge.
REQ-019 At the edge where the counter reaches 0, the block SHALL return to IDLE, set Busy=0, and write {HI,LO} from the pending registers on the same edge.
REQ-020 Busy SHALL be high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES); new HI/LO SHALL be visible from the first cycle with Busy=0.
REQ-021 HI/LO SHALL hold their previous values throughout RUN.
REQ-022 mthi/mtlo SHALL be single-cycle: the accepting edge writes A to HI/LO respectively, with Busy staying 0.
REQ-023 Signed div SHALL truncate the quotient toward zero; the remainder SHALL take the sign of the dividend.
REQ-024 div 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000, with no trap.
REQ-025 Divisor 0 (div or divu) SHALL run the full DIV_CYCLES busy period and leave HI/LO unchanged at completion.
REQ-026 Op 0 or 7 with Start SHALL be a no-op.
REQ-027 Operand inputs SHALL be don't-care after the accepting edge.
REQ-028 Back-to-back operation: Start asserted in the first Busy=0 cycle after completion SHALL be accepted.

Reset
REQ-029 reset=1 SHALL asynchronously force HI=0, LO=0, Busy=0, counter=0, pending registers=0, and state=IDLE.
REQ-030 Reset asserted mid-RUN SHALL abort the operation; no HI/LO write occurs after reset release.
REQ-031 The first Start after reset deassertion SHALL be accepted normally.

Verification
REQ-032 mult A=0xFFFFFFFF, B=0x00000002, Start one cycle -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-033 multu with same operands -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-034 div A=0xFFFFFFF9 (-7), B=2 -> Busy high 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-035 divu A=7, B=0 with HI=0x11, LO=0x22 preloaded via mthi/mtlo -> Busy 10 cycles, HI=0x11, LO=0x22; mthi/mtlo each show Busy=0 and a one-edge update.
REQ-036 mult in flight, then Start with mtlo A=0x5 at cycle 2 -> ignored; final LO = product only.
REQ-037 reset pulse at cycle 3 of a div -> Busy=0, HI=LO=0 immediately; values stay 0 after release until a new op.

Source files
------------

// File: rtl/md_unit.sv
// MIPS-style HI/LO multiply/divide unit: results computed at acceptance, committed after a fixed busy period.
// Latency MULT_CYCLES / DIV_CYCLES; Start is ignored while Busy is high.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  Op,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            wr_q;
    logic [31:0]     hi_q, lo_q;
    logic [31:0]     pend_hi_q, pend_lo_q;

    logic [63:0]     prod_s, prod_u;
    logic [31:0]     a_mag, b_mag, b_mag_div, b_div;
    logic [31:0]     q_mag, r_mag;
    logic [31:0]     quot_s, rem_s, quot_u, rem_u;
    logic            b_zero;

    // Signed division goes through magnitudes so that 0x80000000 / -1 wraps cleanly.
    always_comb begin
        prod_s    = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u    = {32'd0, A} * {32'd0, B};
        b_zero    = (B == 32'd0);
        a_mag     = A[31] ? -A : A;
        b_mag     = B[31] ? -B : B;
        b_mag_div = b_zero ? 32'd1 : b_mag;
        b_div     = b_zero ? 32'd1 : B;
        q_mag     = a_mag / b_mag_div;
        r_mag     = a_mag % b_mag_div;
        quot_s    = (A[31] ^ B[31]) ? -q_mag : q_mag;
        rem_s     = A[31] ? -r_mag : r_mag;
        quot_u    = A / b_div;
        rem_u     = A % b_div;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            wr_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        case (Op)
                            OP_MULT, OP_MULTU: begin
                                pend_hi_q <= (Op == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
                                pend_lo_q <= (Op == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
                                wr_q      <= 1'b1;
                                cnt_q     <= CW'(MULT_CYCLES);
                                busy_q    <= 1'b1;
                                state_q   <= RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                pend_hi_q <= (Op == OP_DIV) ? rem_s  : rem_u;
                                pend_lo_q <= (Op == OP_DIV) ? quot_s : quot_u;
                                // A zero divisor still occupies the unit but never commits.
                                wr_q      <= ~b_zero;
                                cnt_q     <= CW'(DIV_CYCLES);
                                busy_q    <= 1'b1;
                                state_q   <= RUN;
                            end
                            OP_MTHI: hi_q <= A;
                            OP_MTLO: lo_q <= A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (wr_q) begin
                            hi_q <= pend_hi_q;
                            lo_q <= pend_lo_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Randomised and directed bench for md_unit against a cycle-count reference model.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [2:0]  Op;
    logic        Start;
    logic        Busy;
    logic [31:0] HI, LO;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .Op(Op), .Start(Start),
        .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    // Reference model: remaining busy cycles plus the architectural result to commit.
    int          m_rem;
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    bit          p_wr;

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            3'd1: return sa * sb;
            3'd2: return ua * ub;
            3'd3: begin
                if (b == 0) return 64'd0;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd4: begin
                if (b == 0) return 64'd0;
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem <= 0;
            m_hi  <= 0;
            m_lo  <= 0;
            p_hi  <= 0;
            p_lo  <= 0;
            p_wr  <= 0;
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1 && p_wr) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
            end
        end else if (Start) begin
            if (Op >= 3'd1 && Op <= 3'd4) begin
                {p_hi, p_lo} <= ref_result(Op, A, B);
                p_wr  <= !(Op >= 3'd3 && B == 0);
                m_rem <= (Op <= 3'd2) ? 5 : 10;
            end else if (Op == 3'd5) begin
                m_hi <= A;
            end else if (Op == 3'd6) begin
                m_lo <= A;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 64'(Busy), 64'(m_rem > 0));
            chk("hi", 64'(HI), 64'(m_hi));
            chk("lo", 64'(LO), 64'(m_lo));
        end
    end

    // Called at a negedge; drives one Start cycle then scrambles the don't-care operands.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        @(negedge clk);
        Start = 1'b0;
        Op    = 3'($urandom);
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic wait_idle(input string nm, input int exp_cycles);
        int n = 0;
        while (Busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk(nm, 64'(n), 64'(exp_cycles));
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        Start = 1'b0;
        Op    = 3'd0;
        A     = 32'd0;
        B     = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset_state", {31'd0, Busy, HI, LO}, 64'd0);
        reset  = 1'b0;
        cmp_en = 1'b1;

        do_op(3'd1, 32'hFFFF_FFFF, 32'h2);
        wait_idle("mult_busy", 5);
        chk("mult_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFE);

        do_op(3'd2, 32'hFFFF_FFFF, 32'h2);
        wait_idle("multu_busy", 5);
        chk("multu_hilo", {HI, LO}, 64'h0000_0001_FFFF_FFFE);

        do_op(3'd3, 32'hFFFF_FFF9, 32'h2);
        wait_idle("div_busy", 10);
        chk("div_hilo", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);

        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("div_ovf_busy", 10);
        chk("div_ovf_hilo", {HI, LO}, 64'h0000_0000_8000_0000);

        do_op(3'd5, 32'h11, 32'h0);
        chk("mthi", {31'd0, Busy, HI}, 64'h11);
        do_op(3'd6, 32'h22, 32'h0);
        chk("mtlo", {31'd0, Busy, LO}, 64'h22);
        do_op(3'd4, 32'h7, 32'h0);
        wait_idle("divu0_busy", 10);
        chk("divu0_hilo", {HI, LO}, 64'h0000_0011_0000_0022);

        do_op(3'd1, 32'd3, 32'd4);
        Start = 1'b1;
        Op    = 3'd6;
        A     = 32'h5;
        @(negedge clk);
        Start = 1'b0;
        wait_idle("ignore_busy", 4);
        chk("ignore_hilo", {HI, LO}, 64'd12);

        do_op(3'd3, 32'd100, 32'd7);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 chk("abort_reset", {31'd0, Busy, HI, LO}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("abort_hold", {31'd0, Busy, HI, LO}, 64'd0);
        do_op(3'd6, 32'h33, 32'h0);
        chk("after_reset_op", 64'(LO), 64'h33);

        for (int i = 0; i < 400; i++) begin
            Start = ($urandom_range(0, 2) != 0);
            Op    = 3'($urandom);
            A     = pick_val();
            B     = pick_val();
            @(negedge clk);
        end
        Start = 1'b0;
        repeat (12) @(negedge clk);
        cmp_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
